// File: rtl/sdf_r2_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage for the 32-point FFT.
// The twiddle ROM's phase code drives all sequencing: fill the delay line,
// emit sums while storing differences, then replay the differences through
// a complex multiply by the twiddle presented in the same cycle.
module sdf_r2_bf_stage #(
   parameter int DATA_W  = 24,
   parameter int DELAY   = 16,
   parameter int TW_FRAC = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] din_r,
   input  logic [DATA_W-1:0] din_i,
   input  logic [1:0]        state,
   input  logic [DATA_W-1:0] w_r,
   input  logic [DATA_W-1:0] w_i,
   output logic              out_valid,
   output logic [DATA_W-1:0] dout_r,
   output logic [DATA_W-1:0] dout_i
);

   localparam int PW = 2 * DATA_W + 1;

   typedef enum logic [1:0] {
      PH_FILL = 2'd0,
      PH_BFLY = 2'd1,
      PH_TWID = 2'd2,
      PH_DONE = 2'd3
   } phase_t;

   phase_t phase;
   assign phase = phase_t'(state);

   logic [DATA_W-1:0] dl_r [DELAY];
   logic [DATA_W-1:0] dl_i [DELAY];

   logic [DATA_W-1:0] head_r;
   logic [DATA_W-1:0] head_i;
   assign head_r = dl_r[0];
   assign head_i = dl_i[0];

   logic                 shift_en;
   logic [DATA_W-1:0]    push_r;
   logic [DATA_W-1:0]    push_i;
   logic                 res_valid;
   logic [DATA_W-1:0]    res_r;
   logic [DATA_W-1:0]    res_i;
   logic signed [PW-1:0] pr_full;
   logic signed [PW-1:0] pi_full;

   // Full-precision complex product of the delay-line head and the current twiddle
   always_comb begin
      pr_full = PW'($signed(head_r)) * PW'($signed(w_r))
              - PW'($signed(head_i)) * PW'($signed(w_i));
      pi_full = PW'($signed(head_r)) * PW'($signed(w_i))
              + PW'($signed(head_i)) * PW'($signed(w_r));
   end

   // Phase decode: what enters the delay tail and what result goes to the output register
   always_comb begin
      shift_en  = 1'b0;
      push_r    = '0;
      push_i    = '0;
      res_valid = 1'b0;
      res_r     = '0;
      res_i     = '0;
      case (phase)
         PH_FILL: begin
            if (in_valid) begin
               shift_en = 1'b1;
               push_r   = din_r;
               push_i   = din_i;
            end
         end
         PH_BFLY: begin
            if (in_valid) begin
               shift_en  = 1'b1;
               push_r    = head_r - din_r;
               push_i    = head_i - din_i;
               res_valid = 1'b1;
               res_r     = head_r + din_r;
               res_i     = head_i + din_i;
            end
         end
         PH_TWID: begin
            // Arithmetic shift then truncate is just a bit slice of the full product
            shift_en  = 1'b1;
            res_valid = 1'b1;
            res_r     = pr_full[TW_FRAC +: DATA_W];
            res_i     = pi_full[TW_FRAC +: DATA_W];
         end
         default: begin
            shift_en = 1'b0;
         end
      endcase
   end

   // Delay line: shift toward the head whenever a sample is pushed or popped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DELAY; i++) begin
            dl_r[i] <= '0;
            dl_i[i] <= '0;
         end
      end else if (shift_en) begin
         for (int i = 0; i < DELAY - 1; i++) begin
            dl_r[i] <= dl_r[i+1];
            dl_i[i] <= dl_i[i+1];
         end
         dl_r[DELAY-1] <= push_r;
         dl_i[DELAY-1] <= push_i;
      end
   end

   // Output register: one-cycle latency, data holds while no result is produced
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         dout_r    <= '0;
         dout_i    <= '0;
      end else begin
         out_valid <= res_valid;
         if (res_valid) begin
            dout_r <= res_r;
            dout_i <= res_i;
         end
      end
   end

endmodule

// File: tb/tb_sdf_r2_bf_stage.sv
// Self-checking bench for sdf_r2_bf_stage. The bench plays the role of the
// twiddle ROM, drives whole frames and checks every cycle against a
// frame-level reference (sums of halves, twiddled differences).
module tb_sdf_r2_bf_stage;

   localparam int W    = 24;
   localparam int D    = 16;
   localparam int FRAC = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] din_r;
   logic [W-1:0] din_i;
   logic [1:0]   state;
   logic [W-1:0] w_r;
   logic [W-1:0] w_i;
   logic         out_valid;
   logic [W-1:0] dout_r;
   logic [W-1:0] dout_i;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] last_r;
   logic [W-1:0] last_i;

   // W32^k as supplied by the ROM: trunc(256*cos), trunc(256*sin) of 2*pi*k/32
   int tw_r[16] = '{256, 251, 236, 212, 181, 142, 97, 49, 0, -49, -97, -142, -181, -212, -236, -251};
   int tw_i[16] = '{0, 49, 97, 142, 181, 212, 236, 251, 256, 251, 236, 212, 181, 142, 97, 49};

   logic [W-1:0] fr_r  [32];
   logic [W-1:0] fr_i  [32];
   logic [W-1:0] exp_r [32];
   logic [W-1:0] exp_i [32];
   logic [W-1:0] cap_r [32];
   logic [W-1:0] cap_i [32];

   typedef struct {
      string        name;
      logic [W-1:0] ar;
      logic [W-1:0] ai;
      logic [W-1:0] br;
      logic [W-1:0] bi;
      int           k;
      logic [W-1:0] sr;
      logic [W-1:0] si;
      logic [W-1:0] tr;
      logic [W-1:0] ti;
   } vec_t;

   vec_t vecs[7];

   sdf_r2_bf_stage #(.DATA_W(W), .DELAY(D), .TW_FRAC(FRAC)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .state     (state),
      .w_r       (w_r),
      .w_i       (w_i),
      .out_valid (out_valid),
      .dout_r    (dout_r),
      .dout_i    (dout_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint sx(input logic [W-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [W-1:0] lo(input longint v);
      return v[W-1:0];
   endfunction

   // Frame-level reference: X[n]+X[n+16], then (X[k]-X[k+16]) * W32^k
   task automatic buildExpected();
      longint dr, di, pr, pi;
      for (int n = 0; n < 16; n++) begin
         exp_r[n] = lo(sx(fr_r[n]) + sx(fr_r[n+16]));
         exp_i[n] = lo(sx(fr_i[n]) + sx(fr_i[n+16]));
      end
      for (int k = 0; k < 16; k++) begin
         dr = sx(lo(sx(fr_r[k]) - sx(fr_r[k+16])));
         di = sx(lo(sx(fr_i[k]) - sx(fr_i[k+16])));
         pr = dr * longint'(tw_r[k]) - di * longint'(tw_i[k]);
         pi = dr * longint'(tw_i[k]) + di * longint'(tw_r[k]);
         exp_r[16+k] = lo(pr >>> FRAC);
         exp_i[16+k] = lo(pi >>> FRAC);
      end
   endtask

   task automatic driveCycle(input logic rs, input logic v, input logic [1:0] st,
                             input logic [W-1:0] r, input logic [W-1:0] i,
                             input logic [W-1:0] wr, input logic [W-1:0] wi);
      rst      = rs;
      in_valid = v;
      state    = st;
      din_r    = r;
      din_i    = i;
      w_r      = wr;
      w_i      = wi;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic ev,
                              input logic [W-1:0] er, input logic [W-1:0] ei);
      if (ev) begin
         last_r = er;
         last_i = ei;
      end
      total++;
      if (out_valid !== ev) begin
         bad++;
         $display("[TB] FAIL %s out_valid: got %b want %b at %0t", name, out_valid, ev, $time);
      end
      total++;
      if (dout_r !== last_r) begin
         bad++;
         $display("[TB] FAIL %s dout_r: got %h want %h at %0t", name, dout_r, last_r, $time);
      end
      total++;
      if (dout_i !== last_i) begin
         bad++;
         $display("[TB] FAIL %s dout_i: got %h want %h at %0t", name, dout_i, last_i, $time);
      end
   endtask

   task automatic checkValue(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic randomGap(input logic [1:0] st);
      driveCycle(1'b0, 1'b0, st, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      checkOutput("gap", 1'b0, '0, '0);
   endtask

   // Drive one frame; gap_mode 0 none, 1 random gaps, 2 fixed 3-cycle stall in state 1
   task automatic applyStimulus(input int gap_mode, input int n_pops);
      buildExpected();
      for (int n = 0; n < 16; n++) begin
         if (gap_mode == 1 && $urandom_range(0, 3) == 0) randomGap(2'd0);
         driveCycle(1'b0, 1'b1, 2'd0, fr_r[n], fr_i[n], W'($urandom), W'($urandom));
         checkOutput("fill", 1'b0, '0, '0);
      end
      for (int n = 16; n < 32; n++) begin
         if (gap_mode == 1 && $urandom_range(0, 3) == 0) randomGap(2'd1);
         if (gap_mode == 2 && n == 20) begin
            for (int g = 0; g < 3; g++) randomGap(2'd1);
         end
         driveCycle(1'b0, 1'b1, 2'd1, fr_r[n], fr_i[n], W'($urandom), W'($urandom));
         checkOutput("bfly", 1'b1, exp_r[n-16], exp_i[n-16]);
         cap_r[n-16] = dout_r;
         cap_i[n-16] = dout_i;
      end
      for (int k = 0; k < n_pops; k++) begin
         driveCycle(1'b0, 1'($urandom), 2'd2, W'($urandom), W'($urandom), W'(tw_r[k]), W'(tw_i[k]));
         checkOutput("twid", 1'b1, exp_r[16+k], exp_i[16+k]);
         cap_r[16+k] = dout_r;
         cap_i[16+k] = dout_i;
      end
      if (gap_mode == 1 && n_pops == 16) begin
         driveCycle(1'b0, 1'($urandom), 2'd3, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
         checkOutput("done", 1'b0, '0, '0);
      end
   endtask

   task automatic randomFrame();
      for (int n = 0; n < 32; n++) begin
         fr_r[n] = W'($urandom);
         fr_i[n] = W'($urandom);
      end
   endtask

   initial begin
      vecs[0] = '{"const",     W'(100), '0, W'(100),  '0,      0, W'(200), '0,       '0,        '0};
      vecs[1] = '{"alt_k0",    W'(100), '0, W'(-100), '0,      0, '0,      '0,       W'(200),   '0};
      vecs[2] = '{"alt_k4",    W'(100), '0, W'(-100), '0,      4, '0,      '0,       W'(141),   W'(141)};
      vecs[3] = '{"alt_k8",    W'(100), '0, W'(-100), '0,      8, '0,      '0,       '0,        W'(200)};
      vecs[4] = '{"alt_k15",   W'(100), '0, W'(-100), '0,     15, '0,      '0,       W'(-197),  W'(38)};
      vecs[5] = '{"imag_k1",   '0, W'(256), '0,       '0,      1, '0,      W'(256),  W'(-49),   W'(251)};
      vecs[6] = '{"ovf_wrap",  24'h7FFFFF, '0, 24'h7FFFFF, '0, 0, 24'hFFFFFE, '0,   '0,        '0};

      last_r = '0;
      last_i = '0;

      $display("[TB] reset with random inputs");
      for (int c = 0; c < 2; c++) begin
         driveCycle(1'b1, 1'($urandom), 2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
         checkOutput("reset", 1'b0, '0, '0);
      end

      $display("[TB] table vectors");
      for (int v = 0; v < 7; v++) begin
         for (int n = 0; n < 16; n++) begin
            fr_r[n]    = vecs[v].ar;
            fr_i[n]    = vecs[v].ai;
            fr_r[n+16] = vecs[v].br;
            fr_i[n+16] = vecs[v].bi;
         end
         applyStimulus(0, 16);
         checkValue({vecs[v].name, "_sum_r"}, cap_r[0], vecs[v].sr);
         checkValue({vecs[v].name, "_sum_i"}, cap_i[0], vecs[v].si);
         checkValue({vecs[v].name, "_tw_r"},  cap_r[16+vecs[v].k], vecs[v].tr);
         checkValue({vecs[v].name, "_tw_i"},  cap_i[16+vecs[v].k], vecs[v].ti);
      end

      $display("[TB] random frames with gaps");
      for (int f = 0; f < 4; f++) begin
         randomFrame();
         applyStimulus(1, 16);
      end

      $display("[TB] three-cycle stall in butterfly phase");
      randomFrame();
      applyStimulus(2, 16);

      $display("[TB] reset during twiddle replay");
      for (int n = 0; n < 16; n++) begin
         fr_r[n]    = 24'h7FFFFF;
         fr_i[n]    = '0;
         fr_r[n+16] = W'($urandom);
         fr_i[n+16] = W'($urandom);
      end
      applyStimulus(0, 5);
      last_r = '0;
      last_i = '0;
      driveCycle(1'b1, 1'b1, 2'd2, W'($urandom), W'($urandom), W'(tw_r[5]), W'(tw_i[5]));
      checkOutput("rst_mid", 1'b0, '0, '0);
      for (int k = 0; k < 16; k++) begin
         driveCycle(1'b0, 1'b0, 2'd2, W'($urandom), W'($urandom), W'(256), '0);
         checkOutput("post_rst_pop", 1'b1, '0, '0);
      end

      $display("[TB] random frame after reset");
      randomFrame();
      applyStimulus(1, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
